// File: rtl/i2c_target_controller_if.sv
// I2C target bus bundle: open-drain pin levels plus byte-level user handshake.
// Latency/backpressure: none of its own; timing is set by the controller and the bus master.
interface i2c_target_controller_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, tx_req, rx_data, rx_valid, rw, busy, start_det, stop_det
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, tx_req, rx_data, rx_valid, rw, busy, start_det, stop_det
    );
endinterface

// File: rtl/i2c_target_controller.sv
// 7-bit I2C target: receives write bytes, serves read bytes from tx_data; events lag pins by 3 clk.
// No backpressure: bus timing rules, so tx_data must be refreshed before the next tx_req.
module i2c_target_controller #(
    parameter logic [6:0] SLAVE_ADDR = 7'b0000111,
    parameter bit         ACK_DATA   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    i2c_target_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] tx_shift;
    logic       phase;
    logic       sda_oe, busy, rw, rx_valid, tx_req, start_det, stop_det;
    logic [7:0] rx_data;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Synchronizers reset high so the idle bus never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= bus.sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            tx_shift  <= 8'h00;
            phase     <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= start_cond;
            stop_det  <= stop_cond;
            if (start_cond) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_cond) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                phase   <= 1'b0;
                                // shift_reg[6:0] now holds the seven address bits; sda_s2 is R/W.
                                if (shift_reg[6:0] == SLAVE_ADDR) begin
                                    rw    <= sda_s2;
                                    state <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (!rw) begin
                                    sda_oe  <= 1'b0;
                                    bit_cnt <= 4'd0;
                                    state   <= RX_BYTE;
                                end else begin
                                    tx_shift <= {bus.tx_data[6:0], 1'b0};
                                    sda_oe   <= ~bus.tx_data[7];
                                    tx_req   <= 1'b1;
                                    bit_cnt  <= 4'd1;
                                    state    <= TX_BYTE;
                                end
                            end
                        end
                    end
                    RX_BYTE: begin
                        // Byte is published one clk after its 8th rising edge.
                        if (bit_cnt == 4'd8) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            bit_cnt  <= 4'd0;
                            phase    <= 1'b0;
                            state    <= RX_ACK;
                        end else if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= ACK_DATA;
                                phase  <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                phase  <= 1'b0;
                                state  <= RX_BYTE;
                            end
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                phase   <= 1'b0;
                                state   <= TX_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s2) state <= WAIT_STOP;
                            else        phase <= 1'b1;
                        end else if (scl_fall && phase) begin
                            phase    <= 1'b0;
                            tx_shift <= {bus.tx_data[6:0], 1'b0};
                            sda_oe   <= ~bus.tx_data[7];
                            tx_req   <= 1'b1;
                            bit_cnt  <= 4'd1;
                            state    <= TX_BYTE;
                        end
                    end
                    WAIT_STOP: sda_oe <= 1'b0;
                    default:   state  <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_oe;
    assign bus.busy      = busy;
    assign bus.rw        = rw;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.tx_req    = tx_req;
    assign bus.start_det = start_det;
    assign bus.stop_det  = stop_det;
endmodule

// File: tb/tb_i2c_target_controller.sv
// Bench for i2c_target_controller: bit-banged I2C master with wired-AND SDA and byte scoreboards.
module tb_i2c_target_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_target_controller_if bif();

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_line;
    assign sda_line   = m_sda & ~bif.sda_oe;
    assign bif.scl_in = m_scl;
    assign bif.sda_in = sda_line;

    i2c_target_controller #(.SLAVE_ADDR(7'h07), .ACK_DATA(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] tx_src[$];

    int   rx_cnt, tx_cnt, stop_cnt, start_cnt;
    logic oe_seen, busy_seen;

    task automatic clear_mon();
        rx_cnt = 0; tx_cnt = 0; stop_cnt = 0; start_cnt = 0;
        oe_seen = 1'b0; busy_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bif.sda_oe) oe_seen = 1'b1;
            if (bif.busy) busy_seen = 1'b1;
            if (bif.stop_det) stop_cnt++;
            if (bif.start_det) start_cnt++;
            if (bif.rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else check("rx_data", {24'd0, bif.rx_data}, {24'd0, exp_rx.pop_front()});
            end
            if (bif.tx_req) begin
                tx_cnt++;
                bif.tx_data = (tx_src.size() != 0) ? tx_src.pop_front() : 8'hFF;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(5);
        m_scl = 1'b1; tick(10);
        m_sda = 1'b0; tick(10);
        m_scl = 1'b0; tick(5);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(5);
        m_scl = 1'b1; tick(10);
        m_sda = 1'b1; tick(15);
    endtask

    task automatic clock_bit(input logic b, output logic seen, output logic oe);
        m_sda = b; tick(5);
        m_scl = 1'b1; tick(10);
        seen = sda_line;
        oe   = bif.sda_oe;
        tick(10);
        m_scl = 1'b0; tick(5);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_oe, input string tag);
        logic seen, oe;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], seen, oe);
        clock_bit(1'b1, seen, oe);
        check({tag, "_ack_oe"}, {31'd0, oe}, {31'd0, exp_oe});
    endtask

    task automatic read_byte(input logic mack, input string tag);
        logic       seen, oe;
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, seen, oe);
            got[i] = seen;
        end
        if (exp_rd.size() == 0) check({tag, "_unexpected"}, 32'd1, 32'd0);
        else check(tag, {24'd0, got}, {24'd0, exp_rd.pop_front()});
        clock_bit(mack, seen, oe);
    endtask

    initial begin
        logic seen, oe;
        reset = 1'b1;
        bif.tx_data = 8'h00;
        clear_mon();
        tick(4);
        check("rst_sda_oe",   {31'd0, bif.sda_oe},   32'd0);
        check("rst_busy",     {31'd0, bif.busy},     32'd0);
        check("rst_rw",       {31'd0, bif.rw},       32'd0);
        check("rst_rx_data",  {24'd0, bif.rx_data},  32'd0);
        check("rst_rx_valid", {31'd0, bif.rx_valid}, 32'd0);
        check("rst_tx_req",   {31'd0, bif.tx_req},   32'd0);
        reset = 1'b0;
        tick(5);

        // Write 0xAA to our address.
        clear_mon();
        exp_rx.push_back(8'hAA);
        bus_start();
        check("w_start_det", start_cnt, 32'd1);
        write_byte(8'h0E, 1'b1, "w_addr");
        check("w_rw", {31'd0, bif.rw}, 32'd0);
        write_byte(8'hAA, 1'b1, "w_data");
        tick(2);
        check("w_busy_hi", {31'd0, bif.busy}, 32'd1);
        bus_stop();
        check("w_busy_lo",  {31'd0, bif.busy}, 32'd0);
        check("w_rx_cnt",   rx_cnt,   32'd1);
        check("w_stop_cnt", stop_cnt, 32'd1);

        // Address mismatch.
        clear_mon();
        bus_start();
        write_byte(8'h10, 1'b0, "mm_addr");
        write_byte(8'h55, 1'b0, "mm_data");
        bus_stop();
        check("mm_oe_seen",   {31'd0, oe_seen},   32'd0);
        check("mm_rx_cnt",    rx_cnt,             32'd0);
        check("mm_busy_seen", {31'd0, busy_seen}, 32'd0);

        // Read two bytes, master ACKs the first and NACKs the second.
        clear_mon();
        bif.tx_data = 8'h3C;
        tx_src.push_back(8'hC3);
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        bus_start();
        write_byte(8'h0F, 1'b1, "r_addr");
        check("r_rw", {31'd0, bif.rw}, 32'd1);
        read_byte(1'b0, "r_byte0");
        read_byte(1'b1, "r_byte1");
        clock_bit(1'b0, seen, oe);
        check("r_wait_oe",   {31'd0, oe},       32'd0);
        check("r_wait_busy", {31'd0, bif.busy}, 32'd1);
        bus_stop();
        check("r_tx_cnt",  tx_cnt, 32'd2);
        check("r_busy_lo", {31'd0, bif.busy}, 32'd0);

        // Repeated START after 4 data bits of a write, then read address.
        clear_mon();
        bus_start();
        write_byte(8'h0E, 1'b1, "rs_waddr");
        clock_bit(1'b1, seen, oe);
        clock_bit(1'b0, seen, oe);
        clock_bit(1'b1, seen, oe);
        clock_bit(1'b0, seen, oe);
        bus_start();
        write_byte(8'h0F, 1'b1, "rs_raddr");
        check("rs_rw",     {31'd0, bif.rw}, 32'd1);
        check("rs_rx_cnt", rx_cnt,          32'd0);
        bus_stop();
        check("rs_busy_lo", {31'd0, bif.busy}, 32'd0);

        // Reset pulse while the address ACK is being driven.
        clear_mon();
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'h0E >> i) & 8'h01) != 8'h00, seen, oe);
        m_sda = 1'b1; tick(5);
        m_scl = 1'b1; tick(5);
        check("rst_mid_pre_oe", {31'd0, bif.sda_oe}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("rst_mid_oe", {31'd0, bif.sda_oe}, 32'd0);
        reset = 1'b0;
        tick(14);
        m_scl = 1'b0; tick(5);
        bus_stop();
        exp_rx.push_back(8'h5A);
        bus_start();
        write_byte(8'h0E, 1'b1, "rr_addr");
        write_byte(8'h5A, 1'b1, "rr_data");
        bus_stop();
        check("rr_rx_cnt", rx_cnt, 32'd1);

        check("sb_rx_left", exp_rx.size(), 32'd0);
        check("sb_rd_left", exp_rd.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_target_controller.md
I2C_TARGET_CONTROLLER -- requirements
Module: i2c_target_controller

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'b0000111, is the 7-bit address this target answers to.
REQ-002 Parameter ACK_DATA, default 1, means ACK every received data byte; 0 means NACK data bytes (the address is still ACKed).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl_in  input  1  raw SCL pin level (asynchronous).
REQ-006 sda_in  input  1  raw SDA pin level (asynchronous).
REQ-007 sda_oe  output  1  1 = drive SDA low; 0 = release. The top level forms the open-drain pad as sda = sda_oe ? 0 : Z.
REQ-008 tx_data  input  8  byte returned to the master on a read.
REQ-009 tx_req  output  1  one-cycle pulse when tx_data is latched; the user updates tx_data after it.
REQ-010 rx_data  output  8  last received data byte; held until the next byte.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 rw  output  1  R/W bit of the last matched address byte.
REQ-013 busy  output  1  high from address match until STOP.
REQ-014 start_det, stop_det  output  1 each  one-cycle pulses on bus START and bus STOP.

Function
REQ-015 scl_in and sda_in shall each pass a 2-flop synchronizer, then a third register for edge detection. Internal events lag the pins by 3 clk.
REQ-016 START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Both are detected in every state.
REQ-017 Bits shall be sampled on the synchronized SCL rising edge. sda_oe shall change only on the synchronized SCL falling edge, except when reset or STOP clears it.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-019 IDLE: on START go to ADDR with the bit counter at 0.
REQ-020 ADDR: shift 8 bits MSB first. After the 8th bit:
  - if bits[7:1] == SLAVE_ADDR: latch rw and go to ADDR_ACK;
  - otherwise go to WAIT_STOP with sda_oe held at 0.
REQ-021 ADDR_ACK: on the next SCL fall, sda_oe=1 and busy=1. On the following SCL fall:
  - rw=0: release sda_oe and go to RX_BYTE;
  - rw=1: latch tx_data, pulse tx_req, drive bit 7 and go to TX_BYTE.
REQ-022 RX_BYTE: shift 8 bits. One clk after the 8th SCL rise, update rx_data, pulse rx_valid and go to RX_ACK.
REQ-023 RX_ACK: on SCL fall, sda_oe=ACK_DATA. On the next SCL fall, release and return to RX_BYTE.
REQ-024 TX_BYTE: on each SCL fall, set sda_oe = ~current bit, MSB first. After the 8th bit's SCL fall, release SDA and go to TX_ACK.
REQ-025 TX_ACK: sample SDA on the SCL rise.
  - 0 (master ACK): on the SCL fall, latch tx_data, pulse tx_req, drive bit 7 and go to TX_BYTE.
  - 1 (NACK): go to WAIT_STOP.
REQ-026 WAIT_STOP: ignore bits and keep sda_oe=0 until START or STOP.
REQ-027 Repeated START in any state: go to ADDR, counter=0, sda_oe=0, busy cleared; no rx_valid for a partial byte.
REQ-028 STOP in any state: go to IDLE, sda_oe=0, busy=0; a partial byte is discarded.
REQ-029 A general-call address (7'h00) shall not match unless SLAVE_ADDR==0.

Reset
REQ-030 While reset is high:
  - state=IDLE, counters=0;
  - sda_oe=0, busy=0, rw=0, rx_data=8'h00;
  - all pulses low;
  - synchronizer flops set to 1 (bus idle-high).
REQ-031 Reset asserted mid-transfer shall release SDA on the next clk edge. The FSM shall then wait for a fresh START.

Verification
REQ-032 Write to 0x07: START, 0x0E, 0xAA, STOP. The bench shall see:
  - sda_oe=1 during both ACK bits;
  - rx_data=0xAA with one rx_valid pulse;
  - busy 1 then 0; stop_det pulses once.
REQ-033 Address mismatch: START, 0x10, 0x55, STOP. The bench shall see:
  - sda_oe never 1;
  - no rx_valid; busy stays 0.
REQ-034 Read: START, 0x0F, tx_data=0x3C, master ACK, tx_data=0xC3, master NACK, STOP. The bench shall see:
  - SDA bits 00111100 then 11000011;
  - exactly 2 tx_req pulses;
  - WAIT_STOP then IDLE.
REQ-035 Repeated START after 4 data bits of a write, then 0x0F: no rx_valid, rw=1, address ACKed.
REQ-036 Reset pulse while sda_oe=1 during ADDR_ACK: sda_oe=0 on the next clk; a subsequent write of 0x5A is received correctly.
